// File: rtl/cache_split2_5b.sv
// 1-to-2 steering splitter: tokens queue in an in-order FIFO and issue to port 0/1
// by their select bit, with at most one outstanding token per port.
module cache_split2_5b #(
   parameter int DEPTH   = 4,
   parameter int DW      = 5,
   parameter int SEL_BIT = 4,
   localparam int AW     = $clog2(DEPTH),
   localparam int CW     = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_drive,
   input  logic [DW-1:0] i_data,
   output logic          o_free,
   output logic          o_drive0,
   output logic          o_drive1,
   output logic [DW-1:0] o_data0,
   output logic [DW-1:0] o_data1,
   input  logic          i_free0,
   input  logic          i_free1,
   output logic [CW-1:0] o_count,
   output logic          o_overflow,
   output logic          o_err_free
);

   typedef enum logic {ST_IDLE, ST_BUSY} port_state_t;

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          r_free;
   logic [1:0]    r_drive;
   logic [DW-1:0] r_data0;
   logic [DW-1:0] r_data1;
   logic          r_overflow;
   logic          r_err_free;

   logic [DW-1:0] w_head;
   logic          w_tgt;
   logic          w_pop;
   logic          w_push;
   logic          w_full;
   logic [1:0]    w_disp;
   logic [1:0]    w_busy;
   logic [1:0]    w_free_in;
   logic          w_err;

   assign w_free_in = {i_free1, i_free0};
   assign w_head    = r_mem[r_rptr];
   assign w_tgt     = w_head[SEL_BIT];
   // Head-of-line blocking: only the head may issue, and only to an idle port.
   assign w_pop     = (r_count != '0) && !w_busy[w_tgt];
   assign w_disp    = w_pop ? (w_tgt ? 2'b10 : 2'b01) : 2'b00;
   assign w_full    = (r_count == CW'(DEPTH));
   assign w_push    = i_drive && (!w_full || w_pop);
   assign w_err     = |(w_free_in & ~w_busy);

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_port
         port_state_t r_state;
         port_state_t w_state_next;

         always_comb begin
            w_state_next = r_state;
            case (r_state)
               ST_IDLE: if (w_disp[gi])    w_state_next = ST_BUSY;
               ST_BUSY: if (w_free_in[gi]) w_state_next = ST_IDLE;
               default:                    w_state_next = ST_IDLE;
            endcase
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) r_state <= ST_IDLE;
            else     r_state <= w_state_next;
         end

         assign w_busy[gi] = (r_state == ST_BUSY);
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_free     <= 1'b0;
         r_drive    <= 2'b00;
         r_data0    <= '0;
         r_data1    <= '0;
         r_overflow <= 1'b0;
         r_err_free <= 1'b0;
      end else begin
         r_free  <= w_pop;
         r_drive <= w_disp;
         if (w_disp[0]) r_data0 <= w_head;
         if (w_disp[1]) r_data1 <= w_head;
         if (w_push) begin
            r_mem[r_wptr] <= i_data;
            r_wptr        <= r_wptr + 1'b1;
         end
         if (w_pop) r_rptr <= r_rptr + 1'b1;
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
         if (i_drive && !w_push) r_overflow <= 1'b1;
         if (w_err)              r_err_free <= 1'b1;
      end
   end

   assign o_free     = r_free;
   assign o_drive0   = r_drive[0];
   assign o_drive1   = r_drive[1];
   assign o_data0    = r_data0;
   assign o_data1    = r_data1;
   assign o_count    = r_count;
   assign o_overflow = r_overflow;
   assign o_err_free = r_err_free;

endmodule

// File: tb/tb_cache_split2_5b.sv
// Randomized and directed stimulus for cache_split2_5b, checked each cycle against a
// queue-based reference model of the splitter.
module tb_cache_split2_5b;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       i_drive = 1'b0;
   logic [4:0] i_data = '0;
   logic       i_free0 = 1'b0;
   logic       i_free1 = 1'b0;
   logic       o_free, o_drive0, o_drive1, o_overflow, o_err_free;
   logic [4:0] o_data0, o_data1;
   logic [2:0] o_count;

   cache_split2_5b #(.DEPTH(4), .DW(5), .SEL_BIT(4)) dut (
      .clk(clk), .rst(rst),
      .i_drive(i_drive), .i_data(i_data), .o_free(o_free),
      .o_drive0(o_drive0), .o_drive1(o_drive1),
      .o_data0(o_data0), .o_data1(o_data1),
      .i_free0(i_free0), .i_free1(i_free1),
      .o_count(o_count), .o_overflow(o_overflow), .o_err_free(o_err_free)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: token queue plus per-port outstanding flag and held data.
   logic [4:0] m_q[$];
   logic       m_busy[2];
   logic [4:0] m_data[2];
   logic       m_drive[2];
   logic       m_free;
   logic       m_ovf;
   logic       m_err;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_q.delete();
      for (int p = 0; p < 2; p++) begin
         m_busy[p] = 1'b0; m_data[p] = '0; m_drive[p] = 1'b0;
      end
      m_free = 1'b0; m_ovf = 1'b0; m_err = 1'b0;
   endtask

   task automatic check_all(input string tag);
      check_eq({tag, ".drive0"}, 32'(o_drive0), 32'(m_drive[0]));
      check_eq({tag, ".drive1"}, 32'(o_drive1), 32'(m_drive[1]));
      check_eq({tag, ".free"},   32'(o_free),   32'(m_free));
      check_eq({tag, ".data0"},  32'(o_data0),  32'(m_data[0]));
      check_eq({tag, ".data1"},  32'(o_data1),  32'(m_data[1]));
      check_eq({tag, ".count"},  32'(o_count),  32'(m_q.size()));
      check_eq({tag, ".ovf"},    32'(o_overflow), 32'(m_ovf));
      check_eq({tag, ".errf"},   32'(o_err_free), 32'(m_err));
   endtask

   // One clock: apply inputs, advance the model by the splitter's rules, compare.
   task automatic step(input string tag, input logic drv, input logic [4:0] dat,
                       input logic f0, input logic f1);
      logic       pre_busy[2];
      logic       f[2];
      logic       pop;
      int         pre_size;
      logic [4:0] tok;
      i_drive = drv; i_data = dat; i_free0 = f0; i_free1 = f1;
      @(posedge clk);
      f[0] = f0; f[1] = f1;
      pre_busy = m_busy;
      pre_size = m_q.size();
      pop = (pre_size > 0) && !pre_busy[m_q[0][4]];
      m_drive[0] = 1'b0; m_drive[1] = 1'b0;
      m_free = pop;
      for (int p = 0; p < 2; p++) begin
         if (f[p] && pre_busy[p])  m_busy[p] = 1'b0;
         if (f[p] && !pre_busy[p]) m_err = 1'b1;
      end
      if (pop) begin
         tok = m_q.pop_front();
         m_busy[tok[4]] = 1'b1;
         m_data[tok[4]] = tok;
         m_drive[tok[4]] = 1'b1;
      end
      if (drv) begin
         if (pre_size < 4 || pop) m_q.push_back(dat);
         else                     m_ovf = 1'b1;
      end
      #1;
      i_drive = 1'b0; i_free0 = 1'b0; i_free1 = 1'b0;
      check_all(tag);
      $display("step %-6s drv=%0b data=%02h f0=%0b f1=%0b -> d0=%0b d1=%0b free=%0b cnt=%0d ovf=%0b errf=%0b",
               tag, drv, dat, f0, f1, o_drive0, o_drive1, o_free, o_count, o_overflow, o_err_free);
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag, 1'b0, 5'h00, 1'b0, 1'b0);
   endtask

   // Asynchronous reset asserted between edges; outputs must clear before any clock.
   task automatic do_reset(input string tag);
      #2;
      rst = 1'b1;
      #1;
      model_clear();
      check_all(tag);
      $display("reset %s applied mid-cycle", tag);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      model_clear();
      #2;
      check_all("rst0");
      @(posedge clk); #1;
      rst = 1'b0;

      // Single token to port 0, freed two cycles after issue.
      step("t1", 1'b1, 5'h03, 1'b0, 1'b0);
      step("t1", 1'b0, 5'h00, 1'b0, 1'b0);
      check_eq("t1.issue_d0", 32'(o_drive0), 32'd1);
      check_eq("t1.issue_dat", 32'(o_data0), 32'h03);
      idle("t1", 1);
      step("t1", 1'b0, 5'h00, 1'b1, 1'b0);
      idle("t1", 1);

      // Steering both ways, third token blocked behind busy port 1.
      step("t2", 1'b1, 5'h12, 1'b0, 1'b0);
      step("t2", 1'b1, 5'h05, 1'b0, 1'b0);
      step("t2", 1'b1, 5'h17, 1'b0, 1'b0);
      idle("t2", 3);
      check_eq("t2.blocked_cnt", 32'(o_count), 32'd1);
      step("t2", 1'b0, 5'h00, 1'b0, 1'b1);
      step("t2", 1'b0, 5'h00, 1'b0, 1'b0);
      check_eq("t2.issue_d1", 32'(o_data1), 32'h17);
      step("t2", 1'b0, 5'h00, 1'b1, 1'b1);
      idle("t2", 1);

      // Fill with port 0 busy, push+pop at full, then true overflow.
      step("t3", 1'b1, 5'h01, 1'b0, 1'b0);
      for (int i = 2; i <= 5; i++) step("t3", 1'b1, 5'(i), 1'b0, 1'b0);
      idle("t3", 1);
      step("t3", 1'b0, 5'h00, 1'b1, 1'b0);
      step("t3", 1'b1, 5'h06, 1'b0, 1'b0);
      check_eq("t3.full_pp_ovf", 32'(o_overflow), 32'd0);
      step("t3", 1'b1, 5'h07, 1'b0, 1'b0);
      check_eq("t3.ovf", 32'(o_overflow), 32'd1);
      check_eq("t3.cnt", 32'(o_count), 32'd4);
      do_reset("t3r");

      // Head-of-line blocking.
      step("t4", 1'b1, 5'h00, 1'b0, 1'b0);
      step("t4", 1'b1, 5'h01, 1'b0, 1'b0);
      step("t4", 1'b1, 5'h11, 1'b0, 1'b0);
      idle("t4", 3);
      step("t4", 1'b0, 5'h00, 1'b1, 1'b0);
      step("t4", 1'b0, 5'h00, 1'b0, 1'b0);
      step("t4", 1'b0, 5'h00, 1'b0, 1'b0);

      // Spurious free on idle port 1 (it is busy now, so free it first).
      step("t5", 1'b0, 5'h00, 1'b0, 1'b1);
      step("t5", 1'b0, 5'h00, 1'b0, 1'b1);
      check_eq("t5.errf", 32'(o_err_free), 32'd1);
      idle("t5", 1);
      do_reset("t5r");

      // Randomized traffic with consumers freeing at random.
      for (int i = 0; i < 400; i++) begin
         logic f0, f1;
         f0 = (m_busy[0] && $urandom_range(0, 2) == 0) || ($urandom_range(0, 99) == 0);
         f1 = (m_busy[1] && $urandom_range(0, 2) == 0) || ($urandom_range(0, 99) == 0);
         step("rnd", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), f0, f1);
      end
      do_reset("rndr");

      // Mid-operation reset with both ports busy and three tokens queued.
      step("t6", 1'b1, 5'h00, 1'b0, 1'b0);
      step("t6", 1'b1, 5'h10, 1'b0, 1'b0);
      step("t6", 1'b1, 5'h01, 1'b0, 1'b0);
      step("t6", 1'b1, 5'h11, 1'b0, 1'b0);
      step("t6", 1'b1, 5'h02, 1'b0, 1'b0);
      check_eq("t6.cnt", 32'(o_count), 32'd3);
      do_reset("t6r");
      step("t6", 1'b1, 5'h14, 1'b0, 1'b0);
      step("t6", 1'b0, 5'h00, 1'b0, 1'b0);
      check_eq("t6.post_d1", 32'(o_drive1), 32'd1);
      idle("t6", 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
